// File: rtl/mem_access_ctrl_pkg.sv
// Shared funct3 codes, FSM state encoding and access-legality helper for mem_access_ctrl.
package mem_access_ctrl_pkg;

    localparam logic [2:0] LOAD_LB   = 3'b000;
    localparam logic [2:0] LOAD_LH   = 3'b001;
    localparam logic [2:0] LOAD_LW   = 3'b010;
    localparam logic [2:0] LOAD_LBU  = 3'b100;
    localparam logic [2:0] LOAD_LHU  = 3'b101;
    localparam logic [2:0] STORE_SB  = 3'b000;
    localparam logic [2:0] STORE_SH  = 3'b001;
    localparam logic [2:0] STORE_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Reserved funct3 codes are treated as misaligned so they never reach the bus.
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] addr_lo);
        case (sel)
            LOAD_LB, LOAD_LBU: return 1'b0;
            LOAD_LH, LOAD_LHU: return addr_lo[0];
            LOAD_LW:           return (addr_lo != 2'b00);
            default:           return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane steering: byte enables, replicated store data, shifted/extended load data.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        shifted    = rdata >> {addr_lo, 3'b000};
        rdata_ext  = shifted;

        case (sel[1:0])
            STORE_SB[1:0]: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            STORE_SH[1:0]: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            STORE_SW[1:0]: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
        endcase

        case (sel)
            LOAD_LB:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            LOAD_LH:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            LOAD_LBU: rdata_ext = {24'h000000, shifted[7:0]};
            LOAD_LHU: rdata_ext = {16'h0000, shifted[15:0]};
            default:  rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer onto a single-ported data bus (IDLE -> BUS -> RESP).
// Optional bus-wait timeout with O_bus_err when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_req,
    input  logic              I_we,
    input  logic [2:0]        I_sel,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic [31:0]       I_wdata,
    output logic              O_ready,
    output logic              O_done,
    output logic [31:0]       O_rdata,
    output logic              O_misaligned,
    output logic              O_bus_req,
    output logic              O_bus_we,
    output logic [ADDR_W-1:0] O_bus_addr,
    output logic [3:0]        O_bus_be,
    output logic [31:0]       O_bus_wdata,
    input  logic              I_bus_ack,
    input  logic [31:0]       I_bus_rdata
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    output logic              O_bus_err
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must lie within 1..255");
    end

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    mem_lane_align u_lane_align (
        .sel        (sel_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (I_bus_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mis_d        = mis_q;
        rdata_d      = rdata_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
        O_bus_err    = 1'b0;
`endif
        O_ready      = 1'b0;
        O_done       = 1'b0;
        O_misaligned = 1'b0;
        O_bus_req    = 1'b0;
        O_bus_we     = 1'b0;
        O_bus_addr   = '0;
        O_bus_be     = '0;
        O_bus_wdata  = '0;

        case (state_q)
            IDLE: begin
                O_ready = 1'b1;
                if (I_req) begin
                    we_d    = I_we;
                    sel_d   = I_sel;
                    addr_d  = I_addr;
                    wdata_d = I_wdata;
                    mis_d   = is_misaligned(I_sel, I_addr[1:0]);
                    state_d = mis_d ? RESP : BUS;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            BUS: begin
                // Bus fields are driven only while requesting, so idle bus lines read as zero.
                O_bus_req   = 1'b1;
                O_bus_we    = we_q;
                O_bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                O_bus_be    = lane_be;
                O_bus_wdata = lane_wdata;
                if (I_bus_ack) begin
                    if (!we_q) begin
                        rdata_d = lane_rdata;
                    end
                    state_d = RESP;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                O_done       = 1'b1;
                O_misaligned = mis_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
                O_bus_err    = err_q;
`endif
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign O_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver queues expectations, negedge monitors compare.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  sel = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        ready, done, misaligned, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic        bus_err;
`endif

    mem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_req        (req),
        .I_we         (we),
        .I_sel        (sel),
        .I_addr       (addr),
        .I_wdata      (wdata),
        .O_ready      (ready),
        .O_done       (done),
        .O_rdata      (rdata),
        .O_misaligned (misaligned),
        .O_bus_req    (bus_req),
        .O_bus_we     (bus_we),
        .O_bus_addr   (bus_addr),
        .O_bus_be     (bus_be),
        .O_bus_wdata  (bus_wdata),
        .I_bus_ack    (ack),
        .I_bus_rdata  (bus_rdata)
`ifdef MEM_ACCESS_TIMEOUT_EN
        , .O_bus_err  (bus_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          done_cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } busx_t;

    resp_t       resp_q[$];
    busx_t       bus_q[$];
    logic [31:0] model_rdata = '0;
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Response monitor
    always @(negedge clk) begin
        resp_t e;
        if (!rst) begin
            if (done) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = resp_q.pop_front();
                    chk("rdata", rdata, e.rdata);
                    chk("misaligned", misaligned, e.mis);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("ready_in_resp", ready, 0);
`ifdef MEM_ACCESS_TIMEOUT_EN
                    chk("bus_err", bus_err, e.err);
`endif
                    model_rdata = e.rdata;
                end
            end else begin
                chk("rdata_hold", rdata, model_rdata);
                chk("misaligned_idle", misaligned, 0);
            end
        end
    end

    // Bus monitor
    always @(negedge clk) begin
        if (!rst && bus_req) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_req", bus_req, 0);
            end else begin
                chk("bus_addr", bus_addr, bus_q[0].addr);
                chk("bus_we", bus_we, bus_q[0].we);
                chk("bus_be", bus_be, bus_q[0].be);
                if (bus_q[0].we) chk("bus_wdata", bus_wdata, bus_q[0].wdata);
            end
        end
    end

    // waits < 0: never acknowledge (timeout build only)
    task automatic access(input logic a_we, input logic [2:0] a_sel, input logic [31:0] a_addr,
                          input logic [31:0] a_wdata, input logic [31:0] a_brdata, input int waits,
                          input logic [31:0] e_rdata, input logic e_mis, input logic e_err,
                          input logic [3:0] e_be, input logic [31:0] e_wdata);
        int  n;
        bit  found;
        int  lat;
        @(posedge clk); #1;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", ready, 1);
            return;
        end
        req   = 1'b1;
        we    = a_we;
        sel   = a_sel;
        addr  = a_addr;
        wdata = a_wdata;
        lat   = e_mis ? 0 : ((waits < 0) ? 4 : waits + 1);
        resp_q.push_back('{rdata: e_rdata, mis: e_mis, err: e_err, done_cyc: cyc + 1 + lat});
        if (!e_mis) bus_q.push_back('{addr: {a_addr[31:2], 2'b00}, we: a_we, be: e_be, wdata: e_wdata});
        @(posedge clk); #1;
        req   = 1'b0;
        we    = 1'($urandom);
        sel   = 3'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        if (!e_mis && waits >= 0) begin
            repeat (waits) begin
                @(posedge clk); #1;
            end
            ack       = 1'b1;
            bus_rdata = a_brdata;
            @(posedge clk); #1;
            ack       = 1'b0;
            bus_rdata = $urandom;
        end
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        if (!found) chk("done_timeout", done, 1);
        if (!e_mis && bus_q.size() > 0) bus_q.delete(0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        //     we  sel     addr       wdata         bus rdata     wait exp rdata      mis err be     exp wdata
        access(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h0);
        access(0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 1, 32'hFFFFFF80, 0, 0, 4'h8, 32'h0);
        access(0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 0, 32'h00000080, 0, 0, 4'h8, 32'h0);
        access(1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        3, 32'h00000080, 0, 0, 4'hC, 32'hABCDABCD);
        access(0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 32'h00000080, 1, 0, 4'hF, 32'h0);
        access(0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 32'h00000080, 1, 0, 4'hF, 32'h0);
        access(0, 3'b011, 32'h300, 32'h0,        32'h0,        0, 32'h00000080, 1, 0, 4'hF, 32'h0);
        access(0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 2, 32'hFFFF8001, 0, 0, 4'hC, 32'h0);
        access(0, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 0, 32'h00008001, 0, 0, 4'hC, 32'h0);
        access(1, 3'b000, 32'h105, 32'h123456A5, 32'h0,        1, 32'h00008001, 0, 0, 4'h2, 32'hA5A5A5A5);
        access(1, 3'b010, 32'h208, 32'h11223344, 32'h0,        0, 32'h00008001, 0, 0, 4'hF, 32'h11223344);
        access(0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 0, 32'h0000007F, 0, 0, 4'h2, 32'h0);

        // Async reset in the middle of a bus cycle, then a stray ack
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; sel = 3'b010; addr = 32'h100;
        bus_q.push_back('{addr: 32'h100, we: 1'b0, be: 4'hF, wdata: 32'h0});
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk); #2;
        bus_q.delete();
        resp_q.delete();
        model_rdata = '0;
        rst = 1'b1;
        #1;
        chk("midbus_rst_bus_req", bus_req, 0);
        chk("midbus_rst_ready", ready, 1);
        chk("midbus_rst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ack = 1'b1;
        bus_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
            chk("no_bus_req_after_rst", bus_req, 0);
        end

        access(0, 3'b010, 32'h010, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0, 4'hF, 32'h0);
`ifdef MEM_ACCESS_TIMEOUT_EN
        access(0, 3'b010, 32'h400, 32'h0, 32'h0, -1, 32'hCAFEF00D, 0, 1, 4'hF, 32'h0);
        access(0, 3'b100, 32'h402, 32'h0, 32'h00C30000, 0, 32'h000000C3, 0, 0, 4'h4, 32'h0);
`endif

        for (int i = 0; i < 20 && resp_q.size() != 0; i++) @(negedge clk);
        if (resp_q.size() != 0) chk("drain", resp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
